intt_scale_pipe: RTL and testbench

Streaming multi-lane modular scaler computing `out = in · 2^(−s) mod q`, where `s` is a per-beat runtime shift in `0..MAX_SHIFT`. It sits at the tail of the INTT datapath, applying the final `N^(−1)` scaling for power-of-two `N`, and it also serves partial-length transforms. The core is a chain of single-cycle modular halving stages with a valid/ready handshake and global-stall backpressure. It generalises the fixed single-halving scaler.

---
 rtl/intt_scale_pipe.sv | 155 +++++++++++++++
 tb/tb_intt_scale_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intt_scale_pipe.sv
// intt_scale_pipe: streaming multi-lane modular scaler, out = in * 2^(-s) mod q.
//
// A chain of MAX_SHIFT registered halving stages. Each stage carries LANES
// coefficients, the beat's clamped shift s and a valid bit. Stage k halves every
// lane when k < s and otherwise passes the lane through, so every beat has the
// same latency of MAX_SHIFT cycles regardless of s. Backpressure is a global stall:
// the whole chain advances only when the output register is empty or being consumed.
//
// Optional feature macro: INTT_SCALE_RANGE_CHECK_EN
//   When defined, accepted lanes are compared against q and a sticky range_err
//   flag is raised the cycle after any lane >= q. It clears only on rst.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   q          odd modulus, held stable while beats are in flight
//   in_data    LANES coefficients, lane i at [i*LOGQ +: LOGQ], each < q
//   in_shift   requested scale exponent, clamped to MAX_SHIFT
//   in_valid   input beat present
//   in_ready   input beat accepted (low during rst)
//   out_data   scaled lanes (last stage register)
//   out_valid  output beat present (last stage register)
//   out_ready  downstream accepts the output beat
//   range_err  sticky out-of-range flag (only with INTT_SCALE_RANGE_CHECK_EN)

module intt_scale_pipe #(
    parameter int unsigned LOGQ      = 54,
    parameter int unsigned LANES     = 4,
    parameter int unsigned MAX_SHIFT = 17,
    localparam int unsigned SW       = $clog2(MAX_SHIFT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LOGQ-1:0]       q,
    input  logic [LANES*LOGQ-1:0] in_data,
    input  logic [SW-1:0]         in_shift,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LANES*LOGQ-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef INTT_SCALE_RANGE_CHECK_EN
    ,
    output logic                  range_err
`endif
);

    localparam logic [SW-1:0] SMax = SW'(MAX_SHIFT);

    // Modular halving. For odd x, (x + q) / 2 == (x >> 1) + (q >> 1) + 1 because
    // both x and q are odd; using (q >> 1) + 1 avoids the LOGQ+1 bit q + 1.
    // For x < q the sum stays below q, so no carry and no reduction.
    function automatic logic [LOGQ-1:0] halve(input logic [LOGQ-1:0] x,
                                              input logic [LOGQ-1:0] h);
        logic [LOGQ-1:0] r;
        r = x >> 1;
        if (x[0]) begin
            r = r + h;
        end
        return r;
    endfunction

    logic            adv;
    logic            accept;
    logic [SW-1:0]   in_s;
    logic [LOGQ-1:0] half_q;

    // Stage registers: data after halving in stage k, the beat's s, valid.
    logic [LOGQ-1:0] data_q  [MAX_SHIFT][LANES];
    logic [SW-1:0]   shift_q [MAX_SHIFT];
    logic            valid_q [MAX_SHIFT];

    // Inputs seen by the combinational halving in front of each stage register.
    logic [LOGQ-1:0] st_in_data  [MAX_SHIFT][LANES];
    logic [SW-1:0]   st_in_shift [MAX_SHIFT];
    logic            st_in_valid [MAX_SHIFT];

    assign out_valid = valid_q[MAX_SHIFT-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !rst;
    assign accept    = in_valid && in_ready;
    assign in_s      = (in_shift > SMax) ? SMax : in_shift;
    assign half_q    = (q >> 1) + LOGQ'(1);

    for (genvar k = 0; k < MAX_SHIFT; k++) begin : g_stage
        localparam logic [SW-1:0] StageIdx = SW'(k);

        if (k == 0) begin : g_head
            for (genvar i = 0; i < LANES; i++) begin : g_lane
                assign st_in_data[k][i] = in_data[i*LOGQ +: LOGQ];
            end
            assign st_in_shift[k] = in_s;
            assign st_in_valid[k] = accept;
        end else begin : g_body
            for (genvar i = 0; i < LANES; i++) begin : g_lane
                assign st_in_data[k][i] = data_q[k-1][i];
            end
            assign st_in_shift[k] = shift_q[k-1];
            assign st_in_valid[k] = valid_q[k-1];
        end

        logic do_half;
        assign do_half = st_in_shift[k] > StageIdx;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q[k] <= 1'b0;
                shift_q[k] <= '0;
                for (int i = 0; i < LANES; i++) begin
                    data_q[k][i] <= '0;
                end
            end else if (adv) begin
                valid_q[k] <= st_in_valid[k];
                shift_q[k] <= st_in_shift[k];
                for (int i = 0; i < LANES; i++) begin
                    data_q[k][i] <= do_half ? halve(st_in_data[k][i], half_q)
                                            : st_in_data[k][i];
                end
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_out
        assign out_data[i*LOGQ +: LOGQ] = data_q[MAX_SHIFT-1][i];
    end

    // The last stage's shift has no consumer downstream.
    logic unused_last_shift;
    assign unused_last_shift = ^shift_q[MAX_SHIFT-1];

`ifdef INTT_SCALE_RANGE_CHECK_EN
    logic lane_oor;
    logic range_err_q;

    always_comb begin
        lane_oor = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (in_data[i*LOGQ +: LOGQ] >= q) begin
                lane_oor = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else if (accept && lane_oor) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_intt_scale_pipe.sv
// Self-checking bench for intt_scale_pipe. Accepted beats are turned into expected
// outputs by a reference model (multiplication by the inverse of 2, repeated s
// times, mod q) and queued; a negedge monitor pops and compares on every output
// transfer and also checks the in_ready equation, stall stability and latency.

module tb_intt_scale_pipe;

    localparam int unsigned LOGQ      = 54;
    localparam int unsigned LANES     = 4;
    localparam int unsigned MAX_SHIFT = 17;
    localparam int unsigned SW        = $clog2(MAX_SHIFT + 1);
    localparam int unsigned DW        = LANES * LOGQ;

    logic            clk = 1'b0;
    logic            rst;
    logic [LOGQ-1:0] q;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_shift;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
`ifdef INTT_SCALE_RANGE_CHECK_EN
    logic            range_err;
`endif

    intt_scale_pipe #(
        .LOGQ      (LOGQ),
        .LANES     (LANES),
        .MAX_SHIFT (MAX_SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q         (q),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef INTT_SCALE_RANGE_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   stamp;
        bit            lat;
        bit            skip;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          armed = 0;
    bit          lat_mode = 0;
    bit          ready_rand = 0;
    bit          held_valid = 0;
    logic [DW-1:0] held_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // in * (2^-1)^s mod m, with 2^-1 = (m+1)/2 for odd m.
    function automatic logic [LOGQ-1:0] ref_scale(input logic [LOGQ-1:0] x,
                                                  input int unsigned s,
                                                  input logic [LOGQ-1:0] m);
        logic [127:0] r, inv2, mm;
        mm   = {74'd0, m};
        inv2 = (mm + 128'd1) >> 1;
        r    = {74'd0, x};
        for (int i = 0; i < s; i++) r = (r * inv2) % mm;
        return r[LOGQ-1:0];
    endfunction

    function automatic logic [LOGQ-1:0] rand_below(input logic [LOGQ-1:0] m);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return LOGQ'(r % {10'd0, m});
    endfunction

    // Monitor: model push on input transfer, compare on output transfer.
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (in_ready !== (!rst && (!out_valid || out_ready))) begin
                errors++;
                $display("FAIL in_ready: got %b want %b (cyc %0d)", in_ready,
                         (!rst && (!out_valid || out_ready)), cyc);
            end
            if (held_valid && out_valid) begin
                checks++;
                if (out_data !== held_data) begin
                    errors++;
                    $display("FAIL stall_stable: got %h want %h", out_data, held_data);
                end
            end
            held_valid = out_valid && !out_ready && !rst;
            held_data  = out_data;

            if (!rst && in_valid && in_ready) begin
                exp_t e;
                int unsigned s;
                s = (in_shift > MAX_SHIFT) ? MAX_SHIFT : int'(in_shift);
                e.skip = 0;
                for (int i = 0; i < LANES; i++) begin
                    if (in_data[i*LOGQ +: LOGQ] >= q) e.skip = 1;
                    e.data[i*LOGQ +: LOGQ] = ref_scale(in_data[i*LOGQ +: LOGQ], s, q);
                end
                e.stamp = cyc;
                e.lat   = lat_mode;
                sb.push_back(e);
            end

            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h want none", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (!e.skip) begin
                        for (int i = 0; i < LANES; i++) begin
                            checks++;
                            if (out_data[i*LOGQ +: LOGQ] !== e.data[i*LOGQ +: LOGQ]) begin
                                errors++;
                                $display("FAIL lane%0d: got %0d want %0d", i,
                                         out_data[i*LOGQ +: LOGQ], e.data[i*LOGQ +: LOGQ]);
                            end
                        end
                    end
                    if (e.lat) begin
                        checks++;
                        if (cyc - e.stamp != MAX_SHIFT) begin
                            errors++;
                            $display("FAIL latency: got %0d want %0d", cyc - e.stamp, MAX_SHIFT);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] s);
        int t;
        t = 0;
        in_data  = d;
        in_shift = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        idle(3);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [DW-1:0] rand_beat(input logic [LOGQ-1:0] m);
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*LOGQ +: LOGQ] = rand_below(m);
        return d;
    endfunction

    function automatic logic [DW-1:0] pack4(input logic [LOGQ-1:0] l0, input logic [LOGQ-1:0] l1,
                                            input logic [LOGQ-1:0] l2, input logic [LOGQ-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned c0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_shift = '0;
        q        = 54'd97;
        repeat (2) @(posedge clk);
        #1;
        armed = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data_l0", 64'(out_data[0 +: LOGQ]), 64'd0);
        check("reset_out_data_l3", 64'(out_data[3*LOGQ +: LOGQ]), 64'd0);
`ifdef INTT_SCALE_RANGE_CHECK_EN
        check("reset_range_err", 64'(range_err), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Directed small-q beats, isolated so single-cycle out_valid is visible.
        lat_mode = 1;
        send(pack4(54'd1, 54'd96, 54'd95, 54'd0), SW'(1));
        idle(20);
        send(pack4(54'd1, 54'd1, 54'd50, 54'd2), SW'(3));
        send(pack4(54'd42, 54'd96, 54'd0, 54'd7), SW'(0));
        send(pack4(54'd1, 54'd33, 54'd64, 54'd96), SW'(31));
        send(pack4(54'd1, 54'd33, 54'd64, 54'd96), SW'(17));
        send(pack4(54'd3, 54'd5, 54'd88, 54'd13), SW'(18));
        drain();

        // Back-to-back stream with a full-width modulus.
        q  = 54'h3F_FFFF_FFFF_FFDF;
        c0 = cyc;
        for (int n = 0; n < 300; n++) send(rand_beat(q), SW'($urandom_range(0, 31)));
        check("throughput_cycles", 64'(cyc - c0), 64'd300);
        drain();

        // Random backpressure with gaps on the input side.
        lat_mode   = 0;
        ready_rand = 1;
        for (int n = 0; n < 250; n++) begin
            send(rand_beat(q), SW'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        ready_rand = 0;
        idle(2);

        // Reset with ten beats in flight: they must vanish.
        lat_mode = 1;
        for (int n = 0; n < 10; n++) send(rand_beat(q), SW'($urandom_range(0, 17)));
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);
        idle(25);
        check("post_reset_no_beats", 64'(sb.size()), 64'd0);
        send(rand_beat(q), SW'(5));
        drain();

`ifdef INTT_SCALE_RANGE_CHECK_EN
        check("range_err_valid_only", 64'(range_err), 64'd0);
        q = 54'd97;
        send(pack4(54'd97, 54'd1, 54'd2, 54'd3), SW'(1));
        @(negedge clk);
        check("range_err_set", 64'(range_err), 64'd1);
        idle(25);
        check("range_err_sticky", 64'(range_err), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("range_err_cleared", 64'(range_err), 64'd0);
        idle(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
